// File: rtl/memory.sv
// Unified 256x8 memory: two combinational read ports (fetch, data) and one
// clocked write port on the data address; the lower program region is write-protected.
module memory #(
  parameter int Width      = 256,
  parameter int addr_width = 8,
  parameter int Depth      = 8,
  parameter int Data_base  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [addr_width-1:0] addr1,
  input  logic [addr_width-1:0] addr2,
  input  logic [Depth-1:0]      Wdata,
  input  logic                  WEn,
  output logic [Depth-1:0]      Rdata1,
  output logic [Depth-1:0]      Rdata2
);

  localparam logic [addr_width-1:0] DATA_BASE_ADDR = addr_width'(Data_base);

  logic [Depth-1:0] Mem [Width];
  logic             wr_allowed;

  assign wr_allowed = rst_n && WEn && (addr2 >= DATA_BASE_ADDR);

  // The array carries preloaded program contents, so reset only gates writes
  // and never clears storage.
  always_ff @(posedge clk) begin
    if (wr_allowed) begin
      Mem[addr2] <= Wdata;
    end
  end

  assign Rdata1 = Mem[addr1];
  assign Rdata2 = Mem[addr2];

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for memory: preload, protected/data-region
// writes, reset write-suppression, read-during-write and idle sweeps.
module tb_memory;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr1;
  logic [7:0] addr2;
  logic [7:0] Wdata;
  logic       WEn;
  logic [7:0] Rdata1;
  logic [7:0] Rdata2;

  logic [7:0] model [256];
  int         n_tests;
  int         n_fail;

  memory dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr1  (addr1),
    .addr2  (addr2),
    .Wdata  (Wdata),
    .WEn    (WEn),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_array(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.Mem[i] !== model[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    WEn     = 1'b0;
    addr1   = 8'd0;
    addr2   = 8'd0;
    Wdata   = 8'd0;
    for (int i = 0; i < 256; i++) begin
      dut.Mem[i] = 8'(i);
      model[i]   = 8'(i);
    end
    #1;
    check("rst_rdata1", Rdata1, 8'd0);
    check("rst_rdata2", Rdata2, 8'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    addr1 = 8'd5;
    addr2 = 8'd128;
    #1;
    check("read_p1_5", Rdata1, 8'd5);
    check("read_p2_128", Rdata2, 8'd128);

    // Data-region write of 150 at 200.
    @(negedge clk);
    WEn = 1'b1; addr2 = 8'd200; Wdata = 8'd150;
    tick();
    @(negedge clk);
    WEn = 1'b0; addr1 = 8'd200;
    model[200] = 8'd150;
    #1;
    check("wr200_mem", dut.Mem[200], 8'd150);
    check("wr200_rdata2", Rdata2, 8'd150);
    check("wr200_rdata1", Rdata1, 8'd150);

    // Protected region write ignored.
    @(negedge clk);
    WEn = 1'b1; addr2 = 8'd10; Wdata = 8'hAA; addr1 = 8'd10;
    tick();
    @(negedge clk);
    WEn = 1'b0;
    #1;
    check("prot10_mem", dut.Mem[10], 8'd10);
    check("prot10_rdata1", Rdata1, 8'd10);

    // Boundary: 127 protected, 128 writable.
    @(negedge clk);
    WEn = 1'b1; addr2 = 8'd127; Wdata = 8'h3C;
    tick();
    @(negedge clk);
    addr2 = 8'd128; Wdata = 8'hC3;
    tick();
    @(negedge clk);
    WEn = 1'b0;
    model[128] = 8'hC3;
    #1;
    check("bound127", dut.Mem[127], 8'd127);
    check("bound128", dut.Mem[128], 8'hC3);

    // Write suppressed while in reset, preload intact.
    @(negedge clk);
    rst_n = 1'b0;
    WEn = 1'b1; addr2 = 8'd130; Wdata = 8'h55; addr1 = 8'd130;
    tick();
    #1;
    check("rst_wr130_mem", dut.Mem[130], 8'd130);
    check("rst_wr130_rdata1", Rdata1, 8'd130);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    WEn = 1'b0;
    model[130] = 8'h55;
    #1;
    check("rel_wr130_mem", dut.Mem[130], 8'h55);
    check("rel_wr130_rdata2", Rdata2, 8'h55);
    check_array("array_after_reset");

    // Read-during-write at the same address: old before edge, new after.
    @(negedge clk);
    addr1 = 8'd250; addr2 = 8'd250; Wdata = 8'd7; WEn = 1'b1;
    #1;
    check("rdw_pre_p1", Rdata1, 8'd250);
    check("rdw_pre_p2", Rdata2, 8'd250);
    tick();
    check("rdw_post_p1", Rdata1, 8'd7);
    check("rdw_post_p2", Rdata2, 8'd7);
    @(negedge clk);
    WEn = 1'b0;
    model[250] = 8'd7;

    // WEn held across several edges with changing data writes each time.
    @(negedge clk);
    addr2 = 8'd140; WEn = 1'b1; Wdata = 8'h11;
    tick();
    check("hold_e1", Rdata2, 8'h11);
    @(negedge clk);
    Wdata = 8'h22;
    tick();
    check("hold_e2", Rdata2, 8'h22);
    @(negedge clk);
    Wdata = 8'h33;
    tick();
    check("hold_e3", Rdata2, 8'h33);
    @(negedge clk);
    WEn = 1'b0;
    model[140] = 8'h33;

    // Idle sweep of the data region with changing write data.
    for (int a = 128; a < 256; a++) begin
      @(negedge clk);
      addr2 = 8'(a);
      Wdata = 8'(a ^ 8'h5A);
      addr1 = 8'(255 - a);
    end
    tick();
    check_array("idle_sweep_array");

    // Read sweep of both ports against the model.
    for (int a = 0; a < 256; a += 37) begin
      @(negedge clk);
      addr1 = 8'(a);
      addr2 = 8'(255 - a);
      #1;
      check("sweep_p1", Rdata1, model[a]);
      check("sweep_p2", Rdata2, model[255 - a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
